uart_tx_feeder: RTL

//   Byte buffer and sequencer that sits directly upstream of the UART transmitter.

---
 rtl/uart_tx_feeder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus start/end sequencer in front of a UART transmitter.
// The producer writes bytes at any rate. The feeder then takes them one at a time:
// it pops a byte, presents it on o_tx_data, pulses o_tx_start for one cycle and waits
// for i_tx_end. After that it idles for GUARD_CYCLES so the transmitter is back in
// idle before the next character starts.
//
// Optional feature: define UART_TX_TIMEOUT_EN to build a WAIT_END watchdog. When it
// fires it sets the sticky o_timeout and moves on to GUARD. Without the macro,
// o_timeout is constant 0.
//
// Handshake: there is no backpressure on the write side. A write with i_wr_en high
// is taken iff o_full is low; otherwise it is dropped and o_overflow latches.
// o_tx_start is a single-cycle strobe. i_tx_end counts only in WAIT_END.
// o_dbg_state exposes the sequencer state for checkers.

module uart_tx_feeder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int GUARD_CYCLES   = 5300,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_en,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_overflow,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_end,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic [2:0]            o_dbg_state
);

    localparam int GW = $clog2(GUARD_CYCLES) + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [GW-1:0]       GUARD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_POP      = 3'd1,
        S_LOAD     = 3'd2,
        S_START    = 3'd3,
        S_WAIT_END = 3'd4,
        S_GUARD    = 3'd5
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   level_nx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_acc;
    logic                  pop;
    logic [GW-1:0]         guard_cnt;
    logic                  guard_done;
    logic                  wd_expire;

    // Write/pop qualification and the occupancy after this edge.
    always_comb begin
        wr_acc   = i_wr_en && !o_full;
        pop      = (state == S_POP);
        level_nx = o_level + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, pop};
    end

    // FIFO pointers and registered status flags. A pop happens only in POP, and POP
    // is only entered with a non-empty FIFO. So level never underflows.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_level    <= '0;
            o_empty    <= 1'b1;
            o_full     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (i_wr_en && o_full) begin
                o_overflow <= 1'b1;
            end
            o_level <= level_nx;
            o_empty <= (level_nx == '0);
            o_full  <= (level_nx == DEPTH_L);
        end
    end

    // Storage array. It has no reset because the pointers define which entries are valid.
    always_ff @(posedge i_clk_sys) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
        end
    end

    // Registered read in POP, then capture into the transmitter data register in LOAD.
    // o_tx_data holds its value until the next byte is loaded.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            rd_data   <= '0;
            o_tx_data <= '0;
        end else begin
            if (pop) begin
                rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            if (state == S_LOAD) begin
                o_tx_data <= rd_data;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Sequencer next state. i_tx_end outside WAIT_END has no effect.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (!o_empty) begin
                    state_nx = S_POP;
                end
            end
            S_POP:   state_nx = S_LOAD;
            S_LOAD:  state_nx = S_START;
            S_START: state_nx = S_WAIT_END;
            S_WAIT_END: begin
                if (i_tx_end || wd_expire) begin
                    state_nx = S_GUARD;
                end
            end
            S_GUARD: begin
                if (guard_done) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign guard_done = (guard_cnt == GUARD_LAST);

    // Guard interval counter. It runs only in GUARD and clears itself on exit.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            guard_cnt <= '0;
        end else if (state == S_GUARD) begin
            if (guard_done) begin
                guard_cnt <= '0;
            end else begin
                guard_cnt <= guard_cnt + GW'(1);
            end
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wd_cnt;
    logic        timeout_q;

    assign wd_expire = (state == S_WAIT_END) && !i_tx_end && (wd_cnt == TO_LAST);

    // Watchdog: counts the WAIT_END cycles that have no end pulse. When it fires, the
    // byte is treated as sent.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if ((state == S_WAIT_END) && !i_tx_end) begin
            if (wd_expire) begin
                wd_cnt    <= '0;
                timeout_q <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 32'd1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    assign o_timeout = timeout_q;
`else
    // No watchdog: WAIT_END waits for i_tx_end indefinitely. The comparison below is
    // always false for any legal limit, so o_timeout stays at 0.
    assign wd_expire = 1'b0;
    assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign o_tx_start  = (state == S_START);
    assign o_busy      = (state != S_IDLE);
    assign o_dbg_state = state;

endmodule
